// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Port index: 0 = fetch port, 1 = data port.
    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

    localparam int unsigned MEM_DEPTH_DEFAULT = 256;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the port not served last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last,
    output logic [1:0] gnt_c
);

    always_comb begin
        gnt_c = 2'b00;
        if (req == 2'b11) begin
            gnt_c = (last == PORT1) ? 2'b01 : 2'b10;
        end else begin
            gnt_c = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a read-only fetch port and a read/write data port onto one
// single-cycle memory; one access per IDLE -> SERVE -> RESP round.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BYTE_SIZE  = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   p0_req,
    input  logic [ADDR_WIDTH-1:0]  p0_addr,
    output logic                   p0_gnt,
    output logic                   p0_rvalid,
    output logic                   p0_err,
    output logic [BYTE_SIZE*8-1:0] p0_rdata,

    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [ADDR_WIDTH-1:0]  p1_addr,
    input  logic [BYTE_SIZE*8-1:0] p1_wdata,
    output logic                   p1_gnt,
    output logic                   p1_rvalid,
    output logic                   p1_err,
    output logic [BYTE_SIZE*8-1:0] p1_rdata,

    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [BYTE_SIZE*8-1:0] mem_wd,
    input  logic [BYTE_SIZE*8-1:0] mem_rd
);

    localparam int unsigned DW = BYTE_SIZE * 8;
    localparam int unsigned CW = ADDR_WIDTH + 1;

    state_e                state_q,     state_d;
    port_idx_t             last_q,      last_d;
    port_idx_t             owner_q,     owner_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic                  we_q,        we_d;
    logic [DW-1:0]         wdata_q,     wdata_d;
    logic [DW-1:0]         p0_rdata_q,  p0_rdata_d;
    logic [DW-1:0]         p1_rdata_q,  p1_rdata_d;
    logic                  p0_rvalid_q, p0_rvalid_d;
    logic                  p1_rvalid_q, p1_rvalid_d;
    logic                  p0_err_q,    p0_err_d;
    logic                  p1_err_q,    p1_err_d;

    logic [1:0]            arb_gnt;
    logic                  accept;
    logic                  serve;
    logic [CW-1:0]         addr_end;
    logic                  addr_err;

    rr_arb2 u_rr_arb2 (
        .req   ({p1_req, p0_req}),
        .last  (last_q),
        .gnt_c (arb_gnt)
    );

    // Grants exist only in IDLE and never while reset is held.
    assign accept = rst_n && (state_q == ST_IDLE) && (arb_gnt != 2'b00);
    assign p0_gnt = accept && arb_gnt[0];
    assign p1_gnt = accept && arb_gnt[1];

    // One extra bit so an address near the top of the space cannot wrap.
    assign addr_end = CW'(addr_q) + CW'(BYTE_SIZE);
    assign addr_err = addr_end > CW'(MEM_DEPTH);

    assign serve    = (state_q == ST_SERVE);
    assign mem_we   = serve && (owner_q == PORT1) && we_q && !addr_err;
    assign mem_addr = serve ? addr_q  : '0;
    assign mem_wd   = serve ? wdata_q : '0;

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        p0_err_d    = 1'b0;
        p1_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SERVE;
                    owner_d = arb_gnt[1] ? PORT1 : PORT0;
                    addr_d  = arb_gnt[1] ? p1_addr : p0_addr;
                    we_d    = arb_gnt[1] && p1_we;
                    wdata_d = arb_gnt[1] ? p1_wdata : '0;
                end
            end
            ST_SERVE: begin
                state_d = ST_RESP;
                last_d  = owner_q;
                if (owner_q == PORT0) begin
                    p0_rvalid_d = 1'b1;
                    p0_err_d    = addr_err;
                    if (!addr_err) p0_rdata_d = mem_rd;
                end else begin
                    p1_rvalid_d = 1'b1;
                    p1_err_d    = addr_err;
                    if (!addr_err) p1_rdata_d = mem_rd;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= PORT1;
            owner_q     <= PORT0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_err_q    <= p0_err_d;
            p1_err_q    <= p1_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, reset corner cases and a randomized
// run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned BS    = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned DW    = BS * 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          p0_req, p0_gnt, p0_rvalid, p0_err;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Attached memory: combinational read, write committed just after the edge.
    logic [7:0]  mem [DEPTH];
    logic [32:0] rd_idx;
    logic        pend_we;
    logic [31:0] pend_addr, pend_wd;

    always_comb begin
        mem_rd = '0;
        rd_idx = '0;
        for (int i = 0; i < int'(BS); i++) begin
            rd_idx = {1'b0, mem_addr} + 33'(i);
            if (rd_idx < 33'(DEPTH)) mem_rd[8*i +: 8] = mem[rd_idx[7:0]];
        end
    end

    always @(negedge clk) begin
        pend_we   = mem_we;
        pend_addr = mem_addr;
        pend_wd   = mem_wd;
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
        mem[8'h20] = 8'h0D; mem[8'h21] = 8'hF0; mem[8'h22] = 8'hAD; mem[8'h23] = 8'h0B;
        mem[8'h30] = 8'h00; mem[8'h31] = 8'h00; mem[8'h32] = 8'h00; mem[8'h33] = 8'h00;
        mem[8'hFC] = 8'h11; mem[8'hFD] = 8'h22; mem[8'hFE] = 8'h33; mem[8'hFF] = 8'h44;
        forever begin
            @(posedge clk);
            #1;
            if (pend_we) begin
                for (int i = 0; i < int'(BS); i++)
                    mem[8'(pend_addr + 32'(i))] = pend_wd[8*i +: 8];
            end
        end
    end

    typedef struct {
        logic        r0;
        logic [31:0] a0;
        logic        r1;
        logic        we1;
        logic [31:0] a1;
        logic [31:0] wd1;
        logic        g0;
        logic        g1;
        logic        err;
        logic [31:0] rdata;
        logic        mwe;
    } vec_t;

    vec_t vecs [10];

    logic [7:0] mdl_mem [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p0_addr = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] tb_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < int'(BS); i++) w[8*i +: 8] = mem[8'(a + 32'(i))];
        return w;
    endfunction

    function automatic logic [31:0] mdl_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < int'(BS); i++) w[8*i +: 8] = mdl_mem[8'(a + 32'(i))];
        return w;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'(256 - int'($urandom_range(1, 6)));
            1:       return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            default: return 32'($urandom_range(0, 252));
        endcase
    endfunction

    initial begin
        logic [31:0] old40;
        idle_inputs();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_p0_gnt", 32'(p0_gnt), 0);
        chk("rst_p1_gnt", 32'(p1_gnt), 0);
        chk("rst_p0_rvalid", 32'(p0_rvalid), 0);
        chk("rst_p1_rvalid", 32'(p1_rvalid), 0);
        chk("rst_err", 32'({p0_err, p1_err}), 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wd", mem_wd, 0);

        // ---- single-transaction vectors from a fresh reset ----
        vecs[0] = '{1, 32'h10, 0, 0, 32'h0, 32'h0,               1, 0, 0, 32'hDDCCBBAA, 0};
        vecs[1] = '{0, 32'h0,  1, 1, 32'h20, 32'h12345678,       0, 1, 0, 32'h0BADF00D, 1};
        vecs[2] = '{1, 32'h20, 0, 0, 32'h0, 32'h0,               1, 0, 0, 32'h12345678, 0};
        vecs[3] = '{0, 32'h0,  1, 0, 32'hFD, 32'h0,              0, 1, 1, 32'h0BADF00D, 0};
        vecs[4] = '{1, 32'h30, 1, 0, 32'h10, 32'h0,              1, 0, 0, 32'h00000000, 0};
        vecs[5] = '{1, 32'h10, 1, 0, 32'h30, 32'h0,              0, 1, 0, 32'h00000000, 0};
        vecs[6] = '{1, 32'hFC, 0, 0, 32'h0, 32'h0,               1, 0, 0, 32'h44332211, 0};
        vecs[7] = '{1, 32'hFFFFFFFE, 0, 0, 32'h0, 32'h0,         1, 0, 1, 32'h44332211, 0};
        vecs[8] = '{0, 32'h0,  1, 1, 32'hFD, 32'hCAFEF00D,       0, 1, 1, 32'h00000000, 0};
        vecs[9] = '{0, 32'h0,  1, 1, 32'hFC, 32'hA5A5A5A5,       0, 1, 0, 32'h44332211, 1};

        do_reset();
        for (int v = 0; v < 10; v++) begin
            @(posedge clk); #1;
            p0_req = vecs[v].r0; p0_addr = vecs[v].a0;
            p1_req = vecs[v].r1; p1_we = vecs[v].we1;
            p1_addr = vecs[v].a1; p1_wdata = vecs[v].wd1;
            @(negedge clk);
            chk($sformatf("v%0d_p0_gnt", v), 32'(p0_gnt), 32'(vecs[v].g0));
            chk($sformatf("v%0d_p1_gnt", v), 32'(p1_gnt), 32'(vecs[v].g1));
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk($sformatf("v%0d_serve_mem_we", v), 32'(mem_we), 32'(vecs[v].mwe));
            chk($sformatf("v%0d_serve_mem_addr", v), mem_addr, vecs[v].g1 ? vecs[v].a1 : vecs[v].a0);
            chk($sformatf("v%0d_serve_no_gnt", v), 32'({p0_gnt, p1_gnt}), 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("v%0d_resp_mem_we", v), 32'(mem_we), 0);
            chk($sformatf("v%0d_rvalid", v), 32'({p1_rvalid, p0_rvalid}),
                vecs[v].g1 ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_err", v), 32'({p1_err, p0_err}),
                vecs[v].err ? (vecs[v].g1 ? 32'd2 : 32'd1) : 32'd0);
            chk($sformatf("v%0d_rdata", v), vecs[v].g1 ? p1_rdata : p0_rdata, vecs[v].rdata);
        end
        chk("boundary_write_committed", tb_word(32'hFC), 32'hA5A5A5A5);

        // ---- both ports requesting continuously from reset ----
        @(posedge clk); #1;
        rst_n = 1'b0;
        p0_req = 1'b1; p0_addr = 32'h10;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h30;
        @(negedge clk);
        chk("inrst_gnt", 32'({p0_gnt, p1_gnt}), 0);
        chk("inrst_p0_rdata", p0_rdata, 0);
        chk("inrst_p1_rdata", p1_rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("alt_c%0d_p0_gnt", c), 32'(p0_gnt), 32'((c % 3 == 0) && ((c / 3) % 2 == 0)));
            chk($sformatf("alt_c%0d_p1_gnt", c), 32'(p1_gnt), 32'((c % 3 == 0) && ((c / 3) % 2 == 1)));
            @(posedge clk); #1;
        end

        // ---- reset in the SERVE cycle of a port 1 write ----
        idle_inputs();
        do_reset();
        old40 = tb_word(32'h40);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h40; p1_wdata = ~old40;
        @(negedge clk);
        chk("abort_p1_gnt", 32'(p1_gnt), 1);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("abort_serve_mem_we", 32'(mem_we), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we_drop", 32'(mem_we), 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_mem_wd", mem_wd, 0);
        @(negedge clk);
        chk("abort_no_rvalid_a", 32'({p0_rvalid, p1_rvalid, p0_err, p1_err}), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_no_rvalid_b", 32'({p0_rvalid, p1_rvalid, p0_err, p1_err}), 0);
        p0_req = 1'b1; p0_addr = 32'h50;
        p1_req = 1'b1; p1_addr = 32'h60;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_first_p0_gnt", 32'(p0_gnt), 1);
        chk("abort_first_p1_gnt", 32'(p1_gnt), 0);
        chk("abort_mem_untouched", tb_word(32'h40), old40);

        // ---- randomized traffic against a transaction-level model ----
        begin
            int          next_free, we_cyc, rv_cyc;
            logic        last, rv_port, rv_err, win, g0_prev, g1_prev, gerr, gwe;
            logic [31:0] rd0, rd1, rv_data, we_addr, we_wd, ga;
            idle_inputs();
            do_reset();
            for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = mem[i];
            next_free = 0; we_cyc = -1; rv_cyc = -1;
            last = 1'b1; rv_port = 1'b0; rv_err = 1'b0;
            rd0 = '0; rd1 = '0; rv_data = '0; we_addr = '0; we_wd = '0;
            g0_prev = 1'b0; g1_prev = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if (c > 0) begin @(posedge clk); #1; end
                if (g0_prev) p0_req = 1'b0;
                if (g1_prev) p1_req = 1'b0;
                if (!p0_req && $urandom_range(0, 2) == 0) begin
                    p0_req = 1'b1; p0_addr = rand_addr();
                end
                if (!p1_req && $urandom_range(0, 2) == 0) begin
                    p1_req = 1'b1; p1_we = 1'($urandom_range(0, 1));
                    p1_addr = rand_addr(); p1_wdata = $urandom;
                end
                @(negedge clk);
                win = 1'b0;
                if (c >= next_free && (p0_req || p1_req))
                    win = (p0_req && p1_req) ? !last : p1_req;
                chk("rnd_p0_gnt", 32'(p0_gnt), 32'(c >= next_free && (p0_req || p1_req) && !win));
                chk("rnd_p1_gnt", 32'(p1_gnt), 32'(c >= next_free && (p0_req || p1_req) && win));
                chk("rnd_mem_we", 32'(mem_we), 32'(c == we_cyc));
                if (c == we_cyc) begin
                    chk("rnd_mem_addr", mem_addr, we_addr);
                    chk("rnd_mem_wd", mem_wd, we_wd);
                end
                chk("rnd_p0_rvalid", 32'(p0_rvalid), 32'(c == rv_cyc && rv_port == 1'b0));
                chk("rnd_p1_rvalid", 32'(p1_rvalid), 32'(c == rv_cyc && rv_port == 1'b1));
                chk("rnd_p0_err", 32'(p0_err), 32'(c == rv_cyc && rv_port == 1'b0 && rv_err));
                chk("rnd_p1_err", 32'(p1_err), 32'(c == rv_cyc && rv_port == 1'b1 && rv_err));
                if (c == rv_cyc && !rv_err) begin
                    if (rv_port) rd1 = rv_data; else rd0 = rv_data;
                end
                chk("rnd_p0_rdata", p0_rdata, rd0);
                chk("rnd_p1_rdata", p1_rdata, rd1);
                if (c >= next_free && (p0_req || p1_req)) begin
                    ga   = win ? p1_addr : p0_addr;
                    gwe  = win && p1_we;
                    gerr = (longint'(ga) + longint'(BS)) > longint'(DEPTH);
                    rv_port = win; rv_err = gerr; rv_cyc = c + 2;
                    if (!gerr) rv_data = mdl_word(ga);
                    if (gwe && !gerr) begin
                        for (int i = 0; i < int'(BS); i++)
                            mdl_mem[8'(ga + 32'(i))] = p1_wdata[8*i +: 8];
                        we_cyc = c + 1; we_addr = ga; we_wd = p1_wdata;
                    end
                    next_free = c + 3;
                    last = win;
                end
                g0_prev = p0_gnt;
                g1_prev = p1_gnt;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
